fp_align_sequencer: RTL and testbench
=====================================

Name: fp_align_sequencer

Overview:
- Multi-cycle alignment front end for the FP adder.
- Accepts two operands, each an exponent plus an extended significand (hidden bit, fraction, guard/round/sticky), over a valid/ready handshake.
- Compares the exponents and swaps the operands so the larger-exponent operand is "big".
- Right-shifts the smaller significand by the exponent difference, at most STEP bits per cycle, folding shifted-out bits into the sticky bit.
- Presents the aligned pair to the adder core over a second valid/ready handshake.

Parameters:
- SIG_BITS, 23, stored fraction width; significand fields are SIG_BITS+4 bits ([SIG_BITS+3:0]: hidden bit, fraction, G, R, S).
- EXP_BITS, 8, exponent width (biased, unsigned).
- STEP, 4, maximum right-shift per SHIFT cycle; legal range 1..SIG_BITS+4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- exp_a  in  EXP_BITS  operand A exponent.
- sig_a  in  SIG_BITS+4  operand A extended significand.
- exp_b  in  EXP_BITS  operand B exponent.
- sig_b  in  SIG_BITS+4  operand B extended significand.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  consumer accepts result.
- exp_out  out  EXP_BITS  larger exponent.
- sig_big  out  SIG_BITS+4  unshifted significand of the larger-exponent operand.
- sig_small  out  SIG_BITS+4  aligned significand of the other operand.
- swapped  out  1  1 when B is the big operand.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; out_valid=0, exp_out=0, sig_big=0, sig_small=0, swapped=0, busy=0.
- in_ready = (state==IDLE) combinationally, so it reads 1 while in reset.
- IDLE: when in_valid && in_ready at an edge, capture all four operand fields and go to CMP. in_valid in any other state is ignored and nothing is captured.
- CMP (1 cycle), operand selection:
  - If exp_a >= exp_b: big=A, small=B, swapped=0. Otherwise big=B, small=A, swapped=1. Ties go to A; significands are never compared.
  - d = exp_big - exp_small, computed as an unsigned EXP_BITS value.
- CMP, next state:
  - If d >= SIG_BITS+4: collapse. sig_small := 1 if any bit of the small significand is set, else 0. Go to DONE.
  - Else if d == 0: go to DONE with sig_small unshifted.
  - Else: remaining := d, go to SHIFT.
- SHIFT, per cycle:
  - s = min(remaining, STEP).
  - sig_small := sig_small >> s, with bit0 replaced by the OR of old sig_small[s:0]. Sticky is preserved and accumulated.
  - remaining -= s; go to DONE when remaining reaches 0.
- DONE:
  - out_valid=1; all outputs are registered and held stable while out_ready=0.
  - On out_valid && out_ready at an edge: out_valid:=0, go to IDLE.
  - There is no same-cycle re-accept; in_ready rises the cycle after the output handshake.
- Latency: with the accept edge at T0 and k = ceil(d/STEP) (k=0 for d=0 or collapse), out_valid is first high after edge T0+1+k.
- Throughput: one operation in flight at a time.
- Reset mid-operation: any state returns to IDLE immediately, the operation is discarded and all outputs clear.
- Arithmetic: no exponent underflow is possible, since big >= small by construction. The same shift and sticky rule applies to denormal inputs (hidden bit 0).

Test Plan:
- Equal exponents: exp_a=exp_b=0x80, sig_a=0x4000000, sig_b=0x6000000 -> swapped=0, exp_out=0x80, sig_big=0x4000000, sig_small=0x6000000; out_valid after T0+1.
- Swap with multi-step shift and sticky: exp_a=0x7E, sig_a=0x4000008, exp_b=0x85, sig_b=0x5000000 (d=7, k=2).
  - Intermediate sig_small = 0x400001.
  - Final: swapped=1, exp_out=0x85, sig_big=0x5000000, sig_small=0x0080001; out_valid after T0+3.
- Boundary shifts:
  - d=4 (=STEP), sig_b=0x4000000 -> one SHIFT cycle, sig_small=0x0400000.
  - d=25, sig_b=0x4000000 -> k=7, sig_small=0x0000002 (sticky 0).
- Collapse: exp_a=0x90, exp_b=0x70 (d=32).
  - sig_b=0x4000000 -> sig_small=0x0000001, no SHIFT cycles.
  - sig_b=0 -> sig_small=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new data.
  - Required: outputs stable, in_ready=0, nothing captured.
  - Then out_ready=1: exactly one transfer, in_ready=1 the next cycle.
- Reset mid-SHIFT: d=20, pull rst_n low during the 3rd SHIFT cycle.
  - Required: out_valid=0, busy=0, in_ready=1 asynchronously.
  - After release, the next operation (case 2 values) produces the correct result.

Source files
------------

// File: rtl/fp_align_sequencer.sv
// Alignment front end for the FP adder: swaps operands so the larger exponent is "big",
// then right-shifts the small significand STEP bits per cycle with sticky accumulation.
module fp_align_sequencer #(
    parameter int SIG_BITS = 23,
    parameter int EXP_BITS = 8,
    parameter int STEP     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXP_BITS-1:0] exp_a,
    input  logic [SIG_BITS+3:0] sig_a,
    input  logic [EXP_BITS-1:0] exp_b,
    input  logic [SIG_BITS+3:0] sig_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXP_BITS-1:0] exp_out,
    output logic [SIG_BITS+3:0] sig_big,
    output logic [SIG_BITS+3:0] sig_small,
    output logic                swapped,
    output logic                busy
);
    localparam int W = SIG_BITS + 4;
    localparam logic [EXP_BITS-1:0] STEP_E = EXP_BITS'(STEP);
    localparam logic [EXP_BITS-1:0] ONE_E  = EXP_BITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_SHIFT, S_DONE} state_t;

    state_t              r_state;
    logic [EXP_BITS-1:0] r_exp_a;
    logic [EXP_BITS-1:0] r_exp_b;
    logic [W-1:0]        r_sig_a;
    logic [W-1:0]        r_sig_b;
    logic [EXP_BITS-1:0] r_remaining;
    logic [EXP_BITS-1:0] r_exp_out;
    logic [W-1:0]        r_sig_big;
    logic [W-1:0]        r_sig_small;
    logic                r_swapped;
    logic                r_out_valid;

    logic                w_a_big;
    logic [EXP_BITS-1:0] w_exp_big;
    logic [EXP_BITS-1:0] w_exp_small;
    logic [EXP_BITS-1:0] w_diff;
    logic [W-1:0]        w_sig_big_sel;
    logic [W-1:0]        w_sig_small_sel;
    logic                w_collapse;
    logic [EXP_BITS-1:0] w_shamt;
    logic [W-1:0]        w_keep_mask;
    logic [W-1:0]        w_shifted;
    logic                w_sticky;
    logic [W-1:0]        w_aligned;
    logic [EXP_BITS-1:0] w_remaining_next;

    // NOTE: every signal below is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        w_a_big         = (r_exp_a >= r_exp_b);
        w_exp_big       = w_a_big ? r_exp_a : r_exp_b;
        w_exp_small     = w_a_big ? r_exp_b : r_exp_a;
        w_sig_big_sel   = w_a_big ? r_sig_a : r_sig_b;
        w_sig_small_sel = w_a_big ? r_sig_b : r_sig_a;
        w_diff          = w_exp_big - w_exp_small;
        w_collapse      = (32'(w_diff) >= 32'(W));

        // Bit s of the old value lands in bit 0, so sticky covers bits [s:0].
        w_shamt          = (r_remaining < STEP_E) ? r_remaining : STEP_E;
        w_keep_mask      = ~({W{1'b1}} << (w_shamt + ONE_E));
        w_sticky         = |(r_sig_small & w_keep_mask);
        w_shifted        = r_sig_small >> w_shamt;
        w_aligned        = {w_shifted[W-1:1], w_sticky};
        w_remaining_next = r_remaining - w_shamt;
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, including
    // the captured operands, is cleared by reset so a discarded operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_sig_a     <= '0;
            r_sig_b     <= '0;
            r_remaining <= '0;
            r_exp_out   <= '0;
            r_sig_big   <= '0;
            r_sig_small <= '0;
            r_swapped   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_exp_a <= exp_a;
                        r_sig_a <= sig_a;
                        r_exp_b <= exp_b;
                        r_sig_b <= sig_b;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_exp_out <= w_exp_big;
                    r_sig_big <= w_sig_big_sel;
                    r_swapped <= !w_a_big;
                    if (w_collapse) begin
                        r_sig_small <= {{(W-1){1'b0}}, |w_sig_small_sel};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_diff == '0) begin
                        r_sig_small <= w_sig_small_sel;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_sig_small <= w_sig_small_sel;
                        r_remaining <= w_diff;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sig_small <= w_aligned;
                    r_remaining <= w_remaining_next;
                    if (w_remaining_next == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign exp_out   = r_exp_out;
    assign sig_big   = r_sig_big;
    assign sig_small = r_sig_small;
    assign swapped   = r_swapped;

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Bench for fp_align_sequencer: directed corner cases plus randomized operand pairs,
// checked against an arithmetic model of exponent compare and sticky-preserving alignment.
module tb_fp_align_sequencer;
    localparam int SIG_BITS = 23;
    localparam int EXP_BITS = 8;
    localparam int STEP     = 4;
    localparam int W        = SIG_BITS + 4;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic [EXP_BITS-1:0] exp_a     = '0;
    logic [EXP_BITS-1:0] exp_b     = '0;
    logic [W-1:0]        sig_a     = '0;
    logic [W-1:0]        sig_b     = '0;
    logic                in_ready;
    logic                out_valid;
    logic [EXP_BITS-1:0] exp_out;
    logic [W-1:0]        sig_big;
    logic [W-1:0]        sig_small;
    logic                swapped;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [EXP_BITS-1:0] e;
        logic [W-1:0]        big;
        logic [W-1:0]        small_in;
        logic                sw;
        int                  d;
        int                  k;
    } ref_t;

    always #5 clk = ~clk;

    fp_align_sequencer #(.SIG_BITS(SIG_BITS), .EXP_BITS(EXP_BITS), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .sig_a     (sig_a),
        .exp_b     (exp_b),
        .sig_b     (sig_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .sig_big   (sig_big),
        .sig_small (sig_small),
        .swapped   (swapped),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Shifting right by n in any number of steps with sticky accumulation leaves bit 0
    // equal to the OR of every original bit at or below position n.
    function automatic logic [W-1:0] align(input logic [W-1:0] v, input int n);
        logic [63:0] x;
        logic [63:0] res;
        int          m;
        m   = (n > W) ? W : n;
        x   = 64'(v);
        res = x >> m;
        res[0] = |(x & ((64'd2 << m) - 64'd1));
        return res[W-1:0];
    endfunction

    function automatic ref_t model(input logic [EXP_BITS-1:0] ea, input logic [W-1:0] sa,
                                   input logic [EXP_BITS-1:0] eb, input logic [W-1:0] sb);
        ref_t r;
        r.sw       = (ea < eb);
        r.e        = r.sw ? eb : ea;
        r.big      = r.sw ? sb : sa;
        r.small_in = r.sw ? sa : sb;
        r.d        = int'(r.e) - int'(r.sw ? ea : eb);
        r.k        = (r.d == 0 || r.d >= W) ? 0 : (r.d + STEP - 1) / STEP;
        return r;
    endfunction

    task automatic run_op(input string tag,
                          input logic [EXP_BITS-1:0] ea, input logic [W-1:0] sa,
                          input logic [EXP_BITS-1:0] eb, input logic [W-1:0] sb,
                          input int hold);
        ref_t r;
        int   lat;
        r = model(ea, sa, eb, sb);
        @(negedge clk);
        check($sformatf("%s.in_ready_idle", tag), 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        exp_a    = ea;
        sig_a    = sa;
        exp_b    = eb;
        sig_b    = sb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 2 && r.k >= 2)
                check($sformatf("%s.mid_sig_small", tag), 64'(sig_small), 64'(align(r.small_in, STEP)));
        end
        check($sformatf("%s.latency", tag), 64'(lat), 64'(1 + r.k));
        check($sformatf("%s.swapped", tag), 64'(swapped), 64'(r.sw));
        check($sformatf("%s.exp_out", tag), 64'(exp_out), 64'(r.e));
        check($sformatf("%s.sig_big", tag), 64'(sig_big), 64'(r.big));
        check($sformatf("%s.sig_small", tag), 64'(sig_small), 64'(align(r.small_in, r.d)));
        check($sformatf("%s.busy_done", tag), 64'(busy), 64'(1));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            exp_a    = ~ea;
            sig_a    = ~sa;
            exp_b    = ~eb;
            sig_b    = ~sb;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.hold%0d.out_valid", tag, i), 64'(out_valid), 64'(1));
            check($sformatf("%s.hold%0d.in_ready", tag, i), 64'(in_ready), 64'(0));
            check($sformatf("%s.hold%0d.exp_out", tag, i), 64'(exp_out), 64'(r.e));
            check($sformatf("%s.hold%0d.sig_big", tag, i), 64'(sig_big), 64'(r.big));
            check($sformatf("%s.hold%0d.sig_small", tag, i), 64'(sig_small), 64'(align(r.small_in, r.d)));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s.post.out_valid", tag), 64'(out_valid), 64'(0));
        check($sformatf("%s.post.in_ready", tag), 64'(in_ready), 64'(1));
        check($sformatf("%s.post.busy", tag), 64'(busy), 64'(0));
        if (hold > 0) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.idle.out_valid", tag), 64'(out_valid), 64'(0));
            check($sformatf("%s.idle.busy", tag), 64'(busy), 64'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea_i;
        int eb_i;
        int dlt;
        int hold;
        logic [W-1:0] sa;
        logic [W-1:0] sb;

        #1;
        check("rst.in_ready", 64'(in_ready), 64'(1));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.exp_out", 64'(exp_out), 64'(0));
        check("rst.sig_big", 64'(sig_big), 64'(0));
        check("rst.sig_small", 64'(sig_small), 64'(0));
        check("rst.swapped", 64'(swapped), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("equal", 8'h80, 27'h4000000, 8'h80, 27'h6000000, 0);
        run_op("swap_d7", 8'h7E, 27'h4000008, 8'h85, 27'h5000000, 0);
        run_op("d4", 8'h84, 27'h5000000, 8'h80, 27'h4000000, 0);
        run_op("d25", 8'h99, 27'h5000000, 8'h80, 27'h4000000, 0);
        run_op("collapse_one", 8'h90, 27'h5000000, 8'h70, 27'h4000000, 0);
        run_op("collapse_zero", 8'h90, 27'h5000000, 8'h70, 27'h0000000, 0);
        run_op("backpressure", 8'h7E, 27'h4000008, 8'h85, 27'h5000000, 5);

        // Reset during the third SHIFT cycle of a d=20 alignment.
        @(negedge clk);
        in_valid = 1'b1;
        exp_a    = 8'h94;
        sig_a    = 27'h5000000;
        exp_b    = 8'h80;
        sig_b    = 27'h4000008;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midrst.busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        check("midrst.busy", 64'(busy), 64'(0));
        check("midrst.in_ready", 64'(in_ready), 64'(1));
        check("midrst.sig_small", 64'(sig_small), 64'(0));
        check("midrst.exp_out", 64'(exp_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 8'h7E, 27'h4000008, 8'h85, 27'h5000000, 0);

        for (int n = 0; n < 24; n++) begin
            ea_i = int'($urandom_range(0, 255));
            dlt  = int'($urandom_range(0, 34));
            eb_i = ($urandom_range(0, 1) == 1) ? ea_i + dlt : ea_i - dlt;
            if (eb_i < 0) eb_i = 0;
            if (eb_i > 255) eb_i = 255;
            sa = W'($urandom);
            sb = W'($urandom);
            if ($urandom_range(0, 3) == 0) sa[W-1] = 1'b0;
            if ($urandom_range(0, 3) == 0) sb[W-1] = 1'b0;
            if ($urandom_range(0, 7) == 0) sb = '0;
            hold = int'($urandom_range(0, 2));
            run_op($sformatf("rand%0d", n), EXP_BITS'(ea_i), sa, EXP_BITS'(eb_i), sb, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
